// File: rtl/seq_detect_sequencer_pkg.sv
// Shared types and helpers for the serial sequence-detector sequencer.
package seq_detect_sequencer_pkg;

    // Sequencer phases: idle, detector clear, bit shifting, final-bit flush, end-of-run pulse.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_SHIFT = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Index width that never collapses to zero bits, so single-entry configurations still elaborate.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_detect_sequencer_pattern_regfile.sv
// Small pattern register file: one write port, combinational read, cleared by reset.
module seq_pattern_regfile
    import seq_detect_sequencer_pkg::*;
#(
    parameter int WORD_W    = 8,
    parameter int NUM_WORDS = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                we,
    input  logic [idx_width(NUM_WORDS)-1:0]     waddr,
    input  logic [WORD_W-1:0]                   wdata,
    input  logic [idx_width(NUM_WORDS)-1:0]     raddr,
    output logic [WORD_W-1:0]                   rdata
);

    localparam int IDX_W = idx_width(NUM_WORDS);

    logic [WORD_W-1:0] regs [NUM_WORDS];

    // Pattern storage; the address decode loop ignores writes to indices beyond NUM_WORDS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                if (we && (waddr == IDX_W'(i))) begin
                    regs[i] <= wdata;
                end
            end
        end
    end

    // Combinational read mux; an out-of-range index reads as zero.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (raddr == IDX_W'(i)) begin
                rdata = regs[i];
            end
        end
    end

endmodule

// File: rtl/seq_detect_sequencer.sv
// Sequencer feeding stored pattern words MSB-first into a 4-in-a-row detector and
// tallying the detector's hits per run.
module seq_detect_sequencer
    import seq_detect_sequencer_pkg::*;
#(
    parameter int WORD_W     = 8,
    parameter int NUM_WORDS  = 4,
    parameter int CNT_W      = 8,
    parameter int CLR_CYCLES = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cfg_we,
    input  logic [idx_width(NUM_WORDS)-1:0]   cfg_addr,
    input  logic [WORD_W-1:0]                 cfg_data,
    input  logic [$clog2(NUM_WORDS+1)-1:0]    run_len,
    input  logic                              start,
    output logic                              det_w,
    input  logic                              det_z,
    output logic                              det_rst,
    output logic                              busy,
    output logic                              done,
    output logic [CNT_W-1:0]                  hit_count,
    output logic [NUM_WORDS-1:0]              hit_mask
);

    localparam int IDX_W = idx_width(NUM_WORDS);
    localparam int LEN_W = $clog2(NUM_WORDS + 1);
    localparam int BIT_W = idx_width(WORD_W);
    localparam int CLR_W = idx_width(CLR_CYCLES);
    localparam int CMP_W = ((IDX_W > LEN_W) ? IDX_W : LEN_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state, state_n;
    logic [IDX_W-1:0]   word_idx, word_n;
    logic [BIT_W-1:0]   bit_idx, bit_n;
    logic [CLR_W-1:0]   clr_cnt, clr_n;
    logic [LEN_W-1:0]   len_q, len_n;
    logic [WORD_W-1:0]  rd_word;
    logic [CMP_W-1:0]   words_done;
    logic               shift_bit;
    logic               hit_qual;
    logic               wr_en;
    logic               accept;

    assign wr_en  = cfg_we && (state == ST_IDLE);
    assign accept = start && (state == ST_IDLE);

    // The read port follows the upcoming word index so det_w can be registered for the next state.
    seq_pattern_regfile #(
        .WORD_W    (WORD_W),
        .NUM_WORDS (NUM_WORDS)
    ) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .raddr (word_n),
        .rdata (rd_word)
    );

    // Next-state, counter and run-length logic; the first bit's z reflects the clear, so it is skipped.
    always_comb begin
        state_n    = state;
        word_n     = word_idx;
        bit_n      = bit_idx;
        clr_n      = clr_cnt;
        len_n      = len_q;
        words_done = CMP_W'(word_idx) + CMP_W'(1);
        shift_bit  = 1'b0;
        hit_qual   = det_z && (((state == ST_SHIFT) && (bit_idx != '0)) || (state == ST_FLUSH));
        case (state)
            ST_IDLE: begin
                if (start) begin
                    len_n   = (run_len > LEN_W'(NUM_WORDS)) ? LEN_W'(NUM_WORDS) : run_len;
                    word_n  = '0;
                    bit_n   = '0;
                    clr_n   = '0;
                    state_n = (run_len == '0) ? ST_DONE : ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt == CLR_W'(CLR_CYCLES - 1)) begin
                    bit_n   = '0;
                    state_n = ST_SHIFT;
                end else begin
                    clr_n = clr_cnt + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (bit_idx == BIT_W'(WORD_W - 1)) begin
                    state_n = ST_FLUSH;
                end else begin
                    bit_n = bit_idx + 1'b1;
                end
            end
            ST_FLUSH: begin
                if (words_done < CMP_W'(len_q)) begin
                    word_n  = word_idx + 1'b1;
                    clr_n   = '0;
                    state_n = ST_CLEAR;
                end else begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        shift_bit = rd_word[BIT_W'(WORD_W - 1) - bit_n];
    end

    // State and index registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            word_idx <= '0;
            bit_idx  <= '0;
            clr_cnt  <= '0;
            len_q    <= '0;
        end else begin
            state    <= state_n;
            word_idx <= word_n;
            bit_idx  <= bit_n;
            clr_cnt  <= clr_n;
            len_q    <= len_n;
        end
    end

    // Detector-facing and status outputs, registered from the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            det_w   <= 1'b0;
            det_rst <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            det_rst <= !((state_n == ST_SHIFT) || (state_n == ST_FLUSH));
            busy    <= (state_n != ST_IDLE);
            done    <= (state_n == ST_DONE);
            case (state_n)
                ST_SHIFT: det_w <= shift_bit;
                ST_FLUSH: det_w <= det_w;
                default:  det_w <= 1'b0;
            endcase
        end
    end

    // Hit tally: cleared on an accepted start, saturating count plus per-word hit flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count <= '0;
            hit_mask  <= '0;
        end else if (accept) begin
            hit_count <= '0;
            hit_mask  <= '0;
        end else if (hit_qual) begin
            if (hit_count != CNT_MAX) begin
                hit_count <= hit_count + 1'b1;
            end
            for (int i = 0; i < NUM_WORDS; i++) begin
                if (word_idx == IDX_W'(i)) begin
                    hit_mask[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_sequencer.sv
// Bench for seq_detect_sequencer: two instances (8-bit and 2-bit hit counters) share stimulus,
// each driving its own behavioural 4-in-a-row detector.
module tb_seq_detect_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_data;
    logic [2:0] run_len;
    logic       start;

    logic       det_w, det_z, det_rst, busy, done;
    logic [7:0] hit_count;
    logic [3:0] hit_mask;

    logic       det_w2, det_z2, det_rst2, busy2, done2;
    logic [1:0] hit_count2;
    logic [3:0] hit_mask2;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0]  model_mem [4];
    int          obs_cycles;
    logic [63:0] obs_bits;
    int          obs_n;
    logic        busy_after_start;

    seq_detect_sequencer #(.WORD_W(8), .NUM_WORDS(4), .CNT_W(8), .CLR_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .run_len(run_len), .start(start), .det_w(det_w), .det_z(det_z), .det_rst(det_rst),
        .busy(busy), .done(done), .hit_count(hit_count), .hit_mask(hit_mask)
    );

    seq_detect_sequencer #(.WORD_W(8), .NUM_WORDS(4), .CNT_W(2), .CLR_CYCLES(1)) dut2 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .run_len(run_len), .start(start), .det_w(det_w2), .det_z(det_z2), .det_rst(det_rst2),
        .busy(busy2), .done(done2), .hit_count(hit_count2), .hit_mask(hit_mask2)
    );

    always #5 clk = ~clk;

    // Behavioural detectors: z=1 once the last four sampled bits are all equal.
    logic [3:0] hist1 = 4'h0;
    logic [3:0] hist2 = 4'h0;
    int         fill1 = 0;
    int         fill2 = 0;

    always @(posedge clk) begin
        if (det_rst) begin
            hist1 <= 4'h0;
            fill1 <= 0;
        end else begin
            hist1 <= {hist1[2:0], det_w};
            fill1 <= (fill1 < 4) ? fill1 + 1 : 4;
        end
    end

    always @(posedge clk) begin
        if (det_rst2) begin
            hist2 <= 4'h0;
            fill2 <= 0;
        end else begin
            hist2 <= {hist2[2:0], det_w2};
            fill2 <= (fill2 < 4) ? fill2 + 1 : 4;
        end
    end

    assign det_z  = (fill1 >= 4) && ((hist1 == 4'hF) || (hist1 == 4'h0));
    assign det_z2 = (fill2 >= 4) && ((hist2 == 4'hF) || (hist2 == 4'h0));

    // Reference model: words actually run, hits per word, totals, mask and serial stream.
    function automatic int clamp_len(input int len);
        return (len > 4) ? 4 : len;
    endfunction

    function automatic int word_hits(input logic [7:0] w);
        int h;
        logic [3:0] win;
        h = 0;
        for (int i = 3; i < 8; i++) begin
            win = {w[10-i], w[9-i], w[8-i], w[7-i]};
            if ((win == 4'hF) || (win == 4'h0)) h++;
        end
        return h;
    endfunction

    function automatic int exp_count(input int len, input int maxv);
        int s;
        s = 0;
        for (int k = 0; k < clamp_len(len); k++) s += word_hits(model_mem[k]);
        return (s > maxv) ? maxv : s;
    endfunction

    function automatic logic [3:0] exp_mask(input int len);
        logic [3:0] m;
        m = 4'h0;
        for (int k = 0; k < clamp_len(len); k++) m[k] = (word_hits(model_mem[k]) > 0);
        return m;
    endfunction

    // Each word appears as its 8 bits MSB-first followed by the held last bit of the flush cycle.
    function automatic logic [63:0] exp_stream(input int len);
        logic [63:0] s;
        logic [7:0]  w;
        s = 64'h0;
        for (int k = 0; k < clamp_len(len); k++) begin
            w = model_mem[k];
            for (int i = 0; i < 8; i++) s = {s[62:0], w[7-i]};
            s = {s[62:0], w[0]};
        end
        return s;
    endfunction

    task automatic load_word(input int addr, input logic [7:0] data);
        @(posedge clk); #1;
        cfg_we   = 1'b1;
        cfg_addr = 2'(addr);
        cfg_data = data;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        model_mem[addr] = data;
    endtask

    // Start is driven just after edge E; obs_cycles is the edge count from E at which done is seen.
    task automatic run_and_observe(input int len, input bit inject);
        obs_bits   = 64'h0;
        obs_n      = 0;
        obs_cycles = -1;
        @(posedge clk); #1;
        start   = 1'b1;
        run_len = 3'(len);
        @(posedge clk); #1;
        start = 1'b0;
        busy_after_start = busy;
        for (int c = 1; c <= 2000; c++) begin
            if (inject && c == 15) begin
                start = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 8'h00;
            end
            if (inject && c == 16) begin
                start = 1'b0; cfg_we = 1'b0;
            end
            if (done) begin
                obs_cycles = c;
                break;
            end
            if (!det_rst) begin
                obs_bits = {obs_bits[62:0], det_w};
                obs_n++;
            end
            @(posedge clk); #1;
        end
        start  = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_data = 8'h00; run_len = 3'd0; start = 1'b0;
        for (int k = 0; k < 4; k++) model_mem[k] = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        tests_run++; if (det_rst !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset det_rst: got %b want 1", det_rst); end
        tests_run++; if (det_w !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset det_w: got %b want 0", det_w); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset busy: got %b want 0", busy); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset done: got %b want 0", done); end
        tests_run++; if (hit_count !== 8'd0) begin tests_failed++; $display("[TB] FAIL reset hit_count: got %0d want 0", hit_count); end
        tests_run++; if (hit_mask !== 4'h0) begin tests_failed++; $display("[TB] FAIL reset hit_mask: got %b want 0000", hit_mask); end
    endtask

    task automatic test_full_run();
        load_word(0, 8'hF0); load_word(1, 8'hFF); load_word(2, 8'hAA); load_word(3, 8'h0F);
        run_and_observe(4, 1'b0);
        tests_run++; if (busy_after_start !== 1'b1) begin tests_failed++; $display("[TB] FAIL full busy: got %b want 1", busy_after_start); end
        tests_run++; if (obs_cycles != 41) begin tests_failed++; $display("[TB] FAIL full done timing: got %0d want 41", obs_cycles); end
        tests_run++; if (hit_count !== 8'(exp_count(4, 255))) begin tests_failed++; $display("[TB] FAIL full hit_count: got %0d want %0d", hit_count, exp_count(4, 255)); end
        tests_run++; if (hit_mask !== exp_mask(4)) begin tests_failed++; $display("[TB] FAIL full hit_mask: got %b want %b", hit_mask, exp_mask(4)); end
        tests_run++; if (obs_n != 36 || obs_bits !== exp_stream(4)) begin tests_failed++; $display("[TB] FAIL full det_w stream: got %0d bits %h want 36 bits %h", obs_n, obs_bits, exp_stream(4)); end
        tests_run++; if (hit_count2 !== 2'(exp_count(4, 3))) begin tests_failed++; $display("[TB] FAIL full hit_count2: got %0d want %0d", hit_count2, exp_count(4, 3)); end
        @(posedge clk); #1;
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL full done pulse width: got %b want 0", done); end
        tests_run++; if (hit_count !== 8'(exp_count(4, 255))) begin tests_failed++; $display("[TB] FAIL full hit_count hold: got %0d want %0d", hit_count, exp_count(4, 255)); end
    endtask

    task automatic test_zero_len();
        run_and_observe(0, 1'b0);
        tests_run++; if (obs_cycles != 1) begin tests_failed++; $display("[TB] FAIL zero done timing: got %0d want 1", obs_cycles); end
        tests_run++; if (hit_count !== 8'd0 || hit_mask !== 4'h0) begin tests_failed++; $display("[TB] FAIL zero counts: got %0d/%b want 0/0000", hit_count, hit_mask); end
        tests_run++; if (obs_n != 0) begin tests_failed++; $display("[TB] FAIL zero det_rst released: got %0d cycles want 0", obs_n); end
    endtask

    task automatic test_saturate();
        load_word(0, 8'hFF);
        run_and_observe(1, 1'b0);
        tests_run++; if (hit_count2 !== 2'd3) begin tests_failed++; $display("[TB] FAIL saturate hit_count2: got %0d want 3", hit_count2); end
        tests_run++; if (hit_count !== 8'(exp_count(1, 255))) begin tests_failed++; $display("[TB] FAIL saturate hit_count: got %0d want %0d", hit_count, exp_count(1, 255)); end
        tests_run++; if (hit_mask2 !== 4'b0001) begin tests_failed++; $display("[TB] FAIL saturate hit_mask2: got %b want 0001", hit_mask2); end
        tests_run++; if (obs_cycles != 11) begin tests_failed++; $display("[TB] FAIL saturate done timing: got %0d want 11", obs_cycles); end
    endtask

    task automatic test_busy_ignore();
        load_word(0, 8'hF0);
        run_and_observe(4, 1'b1);
        tests_run++; if (obs_cycles != 41) begin tests_failed++; $display("[TB] FAIL busy-ignore timing: got %0d want 41", obs_cycles); end
        tests_run++; if (hit_count !== 8'(exp_count(4, 255)) || hit_mask !== exp_mask(4)) begin tests_failed++; $display("[TB] FAIL busy-ignore result: got %0d/%b want %0d/%b", hit_count, hit_mask, exp_count(4, 255), exp_mask(4)); end
        tests_run++; if (obs_bits !== exp_stream(4)) begin tests_failed++; $display("[TB] FAIL busy-ignore stream: got %h want %h", obs_bits, exp_stream(4)); end
        run_and_observe(1, 1'b0);
        tests_run++; if (obs_n != 9 || obs_bits !== exp_stream(1)) begin tests_failed++; $display("[TB] FAIL busy-ignore entry0: got %h want %h", obs_bits, exp_stream(1)); end
    endtask

    task automatic test_reset_mid_run();
        @(posedge clk); #1;
        start = 1'b1; run_len = 3'd4;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (24) @(posedge clk);
        #1;
        tests_run++; if (busy !== 1'b1 || det_rst !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrun shifting: got busy=%b det_rst=%b want 1/0", busy, det_rst); end
        #2 rst = 1'b1;
        #1;
        tests_run++; if (det_rst !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrun reset outputs: got det_rst=%b busy=%b want 1/0", det_rst, busy); end
        tests_run++; if (hit_count !== 8'd0 || hit_mask !== 4'h0 || hit_count2 !== 2'd0) begin tests_failed++; $display("[TB] FAIL midrun reset counts: got %0d/%b/%0d want 0", hit_count, hit_mask, hit_count2); end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) model_mem[k] = 8'h00;
        run_and_observe(4, 1'b0);
        tests_run++; if (obs_n != 36 || obs_bits !== 64'h0) begin tests_failed++; $display("[TB] FAIL midrun entries cleared: got %0d bits %h want 36 zero bits", obs_n, obs_bits); end
        tests_run++; if (hit_count !== 8'(exp_count(4, 255)) || hit_mask !== exp_mask(4)) begin tests_failed++; $display("[TB] FAIL midrun rerun: got %0d/%b want %0d/%b", hit_count, hit_mask, exp_count(4, 255), exp_mask(4)); end
    endtask

    task automatic test_back_to_back();
        load_word(0, 8'hF0); load_word(1, 8'hFF); load_word(2, 8'hAA); load_word(3, 8'h0F);
        run_and_observe(4, 1'b0);
        run_and_observe(4, 1'b0);
        tests_run++; if (obs_cycles != 41) begin tests_failed++; $display("[TB] FAIL b2b timing: got %0d want 41", obs_cycles); end
        tests_run++; if (hit_count !== 8'(exp_count(4, 255)) || hit_mask !== exp_mask(4)) begin tests_failed++; $display("[TB] FAIL b2b result: got %0d/%b want %0d/%b", hit_count, hit_mask, exp_count(4, 255), exp_mask(4)); end
        tests_run++; if (obs_bits !== exp_stream(4)) begin tests_failed++; $display("[TB] FAIL b2b stream: got %h want %h", obs_bits, exp_stream(4)); end
    endtask

    task automatic test_random();
        int len;
        logic [7:0] w;
        for (int it = 0; it < 8; it++) begin
            for (int a = 0; a < 4; a++) begin
                w = 8'($urandom);
                if ($urandom_range(0, 1) == 1) w = {{4{w[0]}}, w[3:0]};
                load_word(a, w);
            end
            len = $urandom_range(0, 7);
            run_and_observe(len, 1'b0);
            tests_run++; if (obs_cycles != clamp_len(len) * 10 + 1) begin tests_failed++; $display("[TB] FAIL random timing len=%0d: got %0d want %0d", len, obs_cycles, clamp_len(len) * 10 + 1); end
            tests_run++; if (hit_count !== 8'(exp_count(len, 255)) || hit_mask !== exp_mask(len)) begin tests_failed++; $display("[TB] FAIL random result len=%0d: got %0d/%b want %0d/%b", len, hit_count, hit_mask, exp_count(len, 255), exp_mask(len)); end
            tests_run++; if (hit_count2 !== 2'(exp_count(len, 3))) begin tests_failed++; $display("[TB] FAIL random hit_count2 len=%0d: got %0d want %0d", len, hit_count2, exp_count(len, 3)); end
            tests_run++; if (obs_n != clamp_len(len) * 9 || obs_bits !== exp_stream(len)) begin tests_failed++; $display("[TB] FAIL random stream len=%0d: got %0d bits %h want %h", len, obs_n, obs_bits, exp_stream(len)); end
        end
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_zero_len();
        test_saturate();
        test_busy_ignore();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
